// File: rtl/sum_reduce_n.sv
// rtl/sum_reduce_n.sv - N-operand adder reducing with ADDERS adders per cycle; optional SUM_REDUCE_SATURATE_EN
module sum_reduce_n #(
  parameter int WIDTH  = 64,
  parameter int N      = 7,
  parameter int ADDERS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               r_enable,
  input  logic [N*WIDTH-1:0] init_vals,
  output logic               w_enable,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  // live spans 0..N; lane index spans 0..N-1; adders beyond N/2 can never be used
  localparam int LW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AC = (ADDERS < N) ? ADDERS : N;

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] v        [N];
  logic [WIDTH-1:0] nv       [N];
  logic [WIDTH-1:0] pair_sum [N];
  logic [LW-1:0]    live, live_next, half, p;
  logic             load, step, finish;

  function automatic logic [WIDTH-1:0] add_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SUM_REDUCE_SATURATE_EN
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  // One adder per adjacent pair; only lanes below p are selected each step
  for (genvar j = 0; j < N; j++) begin : g_pair
    if (2 * j + 1 < N) begin : g_add
      assign pair_sum[j] = add_op(v[2*j], v[2*j+1]);
    end else begin : g_none
      assign pair_sum[j] = '0;
    end
  end

  // One reduction step: pair the front, shift the unpaired tail down behind the sums
  always_comb begin
    half      = live >> 1;
    p         = (half > LW'(AC)) ? LW'(AC) : half;
    live_next = live - p;
    for (int j = 0; j < N; j++) begin
      nv[j] = v[j];
      if (j < int'(p)) begin
        nv[j] = pair_sum[j];
      end else if (j < int'(live_next)) begin
        nv[j] = v[IW'(j + int'(p))];
      end
    end
  end

  // Next state; a start overrides everything, including an in-flight reduction
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    if (r_enable) begin
      state_next = REDUCE;
      load       = 1'b1;
    end else if (state == REDUCE) begin
      step = 1'b1;
      if (live_next == LW'(1)) begin
        finish     = 1'b1;
        state_next = DONE;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand array, live count and result; result only moves on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) v[i] <= '0;
      live   <= '0;
      result <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) v[i] <= init_vals[i*WIDTH +: WIDTH];
      live <= LW'(N);
    end else if (step) begin
      for (int i = 0; i < N; i++) v[i] <= nv[i];
      live <= live_next;
      if (finish) result <= nv[0];
    end
  end

  assign busy     = (state == REDUCE);
  assign w_enable = (state == DONE);

endmodule

// File: tb/tb_sum_reduce_n.sv
// tb/tb_sum_reduce_n.sv - randomized self-checking bench for sum_reduce_n across several configurations
module tb_sum_reduce_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]      re = '0;
  logic [5:0]      we, bz;
  logic [7*64-1:0] iv0 = '0;
  logic [2*8-1:0]  iv1 = '0;
  logic [8*16-1:0] iv2 = '0, iv3 = '0;
  logic [15:0]     iv4 = '0;
  logic [5*12-1:0] iv5 = '0;
  logic [63:0]     r0;
  logic [7:0]      r1;
  logic [15:0]     r2, r3, r4;
  logic [11:0]     r5;

  int tests = 0;
  int fails = 0;
  logic [63:0] cur_ops [8];
  logic [63:0] held [6];
  int cfg_w [6] = '{64, 8, 16, 16, 16, 12};
  int cfg_n [6] = '{7, 2, 8, 8, 1, 5};
  int cfg_a [6] = '{2, 1, 1, 4, 2, 3};

  sum_reduce_n #(.WIDTH(64), .N(7), .ADDERS(2)) dut0 (.clk(clk), .rst_n(rst_n), .r_enable(re[0]), .init_vals(iv0), .w_enable(we[0]), .result(r0), .busy(bz[0]));
  sum_reduce_n #(.WIDTH(8),  .N(2), .ADDERS(1)) dut1 (.clk(clk), .rst_n(rst_n), .r_enable(re[1]), .init_vals(iv1), .w_enable(we[1]), .result(r1), .busy(bz[1]));
  sum_reduce_n #(.WIDTH(16), .N(8), .ADDERS(1)) dut2 (.clk(clk), .rst_n(rst_n), .r_enable(re[2]), .init_vals(iv2), .w_enable(we[2]), .result(r2), .busy(bz[2]));
  sum_reduce_n #(.WIDTH(16), .N(8), .ADDERS(4)) dut3 (.clk(clk), .rst_n(rst_n), .r_enable(re[3]), .init_vals(iv3), .w_enable(we[3]), .result(r3), .busy(bz[3]));
  sum_reduce_n #(.WIDTH(16), .N(1), .ADDERS(2)) dut4 (.clk(clk), .rst_n(rst_n), .r_enable(re[4]), .init_vals(iv4), .w_enable(we[4]), .result(r4), .busy(bz[4]));
  sum_reduce_n #(.WIDTH(12), .N(5), .ADDERS(3)) dut5 (.clk(clk), .rst_n(rst_n), .r_enable(re[5]), .init_vals(iv5), .w_enable(we[5]), .result(r5), .busy(bz[5]));

  function automatic logic [63:0] get_res(input int k);
    case (k)
      0:       return r0;
      1:       return {56'd0, r1};
      2:       return {48'd0, r2};
      3:       return {48'd0, r3};
      4:       return {48'd0, r4};
      default: return {52'd0, r5};
    endcase
  endfunction

  // Steps to bring the operand count down to one, at least one step
  function automatic int n_steps(input int n, input int a);
    int live, p, s;
    live = n;
    s = 0;
    while (live > 1) begin
      p = (live / 2 < a) ? live / 2 : a;
      live = live - p;
      s++;
    end
    return (s == 0) ? 1 : s;
  endfunction

  // True sum of the width-truncated operands, then wrapped or clamped
  function automatic logic [63:0] model_sum(input int k);
    logic [71:0] acc, mask;
    mask = (72'd1 << cfg_w[k]) - 72'd1;
    acc = '0;
    for (int i = 0; i < cfg_n[k]; i++) acc = acc + ({8'd0, cur_ops[i]} & mask);
`ifdef SUM_REDUCE_SATURATE_EN
    if (acc > mask) acc = mask;
`else
    acc = acc & mask;
`endif
    return acc[63:0];
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < 8; i++) begin
      if (i < 7) iv0[i*64 +: 64] = cur_ops[i];
      if (i < 2) iv1[i*8 +: 8] = cur_ops[i][7:0];
      iv2[i*16 +: 16] = cur_ops[i][15:0];
      iv3[i*16 +: 16] = cur_ops[i][15:0];
      if (i < 5) iv5[i*12 +: 12] = cur_ops[i][11:0];
    end
    iv4 = cur_ops[0][15:0];
  endtask

  task automatic fill_ops(input logic [63:0] base, input logic [63:0] incr);
    for (int i = 0; i < 8; i++) cur_ops[i] = base + incr * 64'(i);
  endtask

  // Pulse start on instance k and check busy/w_enable/result on every edge to completion
  task automatic run_and_check(input int k, input string name);
    int s;
    logic [63:0] exp;
    s = n_steps(cfg_n[k], cfg_a[k]);
    exp = model_sum(k);
    @(negedge clk);
    drive_ops();
    re[k] = 1'b1;
    @(negedge clk);
    re[k] = 1'b0;
    tests++;
    if (we[k] !== 1'b0 || bz[k] !== 1'b1) begin
      fails++;
      $display("FAIL %s start: w_enable=%b busy=%b, required 0/1", name, we[k], bz[k]);
    end
    for (int c = 1; c <= s; c++) begin
      @(negedge clk);
      tests++;
      if (c < s) begin
        if (we[k] !== 1'b0 || bz[k] !== 1'b1 || get_res(k) !== held[k]) begin
          fails++;
          $display("FAIL %s step %0d: w_enable=%b busy=%b result=%h, required 0/1/%h", name, c, we[k], bz[k], get_res(k), held[k]);
        end
      end else begin
        if (we[k] !== 1'b1 || bz[k] !== 1'b0 || get_res(k) !== exp) begin
          fails++;
          $display("FAIL %s done: w_enable=%b busy=%b result=%h, required 1/0/%h", name, we[k], bz[k], get_res(k), exp);
        end
      end
    end
    held[k] = exp;
  endtask

  task automatic check_reset_outputs(input string name);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (we[k] !== 1'b0 || bz[k] !== 1'b0 || get_res(k) !== 64'd0) begin
        fails++;
        $display("FAIL %s inst%0d: w_enable=%b busy=%b result=%h, required 0/0/0", name, k, we[k], bz[k], get_res(k));
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 6; k++) held[k] = '0;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sum();
    fill_ops(64'd1, 64'd1);
    run_and_check(0, "basic_sum");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (we[0] !== 1'b1 || r0 !== 64'd28) begin
        fails++;
        $display("FAIL basic_hold cycle %0d: w_enable=%b result=%0d, required 1/28", c, we[0], r0);
      end
    end
  endtask

  task automatic test_start_in_done();
    fill_ops(64'd0, 64'd0);
    run_and_check(0, "start_in_done");
  endtask

  task automatic test_overflow();
    cur_ops[0] = 64'd200;
    cur_ops[1] = 64'd100;
    run_and_check(1, "overflow");
  endtask

  task automatic test_latency();
    fill_ops(64'd3, 64'd0);
    run_and_check(2, "latency_a1");
    run_and_check(3, "latency_a4");
    cur_ops[0] = 64'hDEAD;
    run_and_check(4, "latency_n1");
  endtask

  task automatic test_restart();
    fill_ops(64'd1, 64'd1);
    @(negedge clk);
    drive_ops();
    re[0] = 1'b1;
    @(negedge clk);
    re[0] = 1'b0;
    fill_ops(64'd10, 64'd0);
    run_and_check(0, "restart");
  endtask

  task automatic test_async_reset();
    fill_ops(64'd1, 64'd1);
    @(negedge clk);
    drive_ops();
    re[0] = 1'b1;
    @(negedge clk);
    re[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) held[k] = '0;
    check_reset_outputs("async_reset_reduce");
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check(0, "after_reset_reduce");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) held[k] = '0;
    check_reset_outputs("async_reset_done");
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check(0, "after_reset_done");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      for (int t = 0; t < 8; t++) begin
        for (int i = 0; i < 8; i++) begin
          cur_ops[i] = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        end
        run_and_check(k, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_start_in_done();
    test_overflow();
    test_latency();
    test_restart();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
